// File: rtl/rb_flow_ctrl.sv
// rb_flow_ctrl: valid/ready adapter around a DEPTH-entry byte ring buffer that
// has no status flags and drops the pop when push and pop coincide. Tracks
// occupancy, arbitrates push/pop strobes fairly, and presents popped bytes
// through a one-entry output register.
module rb_flow_ctrl #(
  parameter int DEPTH  = 10,
  parameter int DATA_W = 8,
  parameter int CNT_W  = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              rb_enable,
  output logic              rb_push,
  output logic              rb_pop,
  output logic [DATA_W-1:0] rb_datain,
  input  logic [DATA_W-1:0] rb_dataout,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty
);

  typedef enum logic [1:0] {IDLE, POP_WAIT, OUT_VALID} state_t;
  typedef enum logic {GRANT_POP, GRANT_PUSH} grant_t;

  state_t state, state_nxt;
  grant_t last_grant;
  logic   slot_free, want_pop, want_push;

  // Occupancy flags and request/grant decode; push and pop are mutually exclusive.
  always_comb begin
    full      = (count == CNT_W'(DEPTH));
    empty     = (count == '0);
    slot_free = (state == IDLE) | ((state == OUT_VALID) & m_ready);
    want_pop  = enable & ~empty & slot_free;
    want_push = enable & s_valid & ~full;
    // s_ready is built without s_valid: when a pop is pending and the last grant
    // went to push, the pop wins, so upstream is told not-ready up front.
    s_ready   = enable & ~full & ~(want_pop & (last_grant == GRANT_PUSH));
    rb_push   = s_valid & s_ready;
    rb_pop    = want_pop & ~(want_push & (last_grant == GRANT_POP));
    rb_enable = enable;
    rb_datain = s_data;
  end

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic; POP_WAIT always advances so an in-flight byte is never lost.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (rb_pop) state_nxt = POP_WAIT;
      POP_WAIT:  state_nxt = OUT_VALID;
      OUT_VALID: if (m_ready) state_nxt = rb_pop ? POP_WAIT : IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // Output decode from state.
  always_comb begin
    m_valid = (state == OUT_VALID);
  end

  // Occupancy counter, fairness history and output data register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count      <= '0;
      last_grant <= GRANT_POP;
      m_data     <= '0;
    end else begin
      if (rb_push)     count <= count + CNT_W'(1);
      else if (rb_pop) count <= count - CNT_W'(1);
      if (rb_push)     last_grant <= GRANT_PUSH;
      else if (rb_pop) last_grant <= GRANT_POP;
      if (state == POP_WAIT) m_data <= rb_dataout;
    end
  end

endmodule

// File: tb/tb_rb_flow_ctrl.sv
// Directed testbench for rb_flow_ctrl with a behavioural 10-entry ring buffer.
module tb_rb_flow_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable, s_valid, s_ready, m_valid, m_ready;
  logic [7:0] s_data, m_data, rb_datain, rb_dataout;
  logic       rb_enable, rb_push, rb_pop, full, empty;
  logic [3:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int tx = 0;
  int rx = 0;
  logic       last_push, last_pop;
  logic [3:0] last_count;

  rb_flow_ctrl #(.DEPTH(10), .DATA_W(8), .CNT_W(4)) dut (
    .clock(clock), .reset(reset), .enable(enable),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .rb_enable(rb_enable), .rb_push(rb_push), .rb_pop(rb_pop),
    .rb_datain(rb_datain), .rb_dataout(rb_dataout),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  // Ring buffer model: push wins over pop, dataout registered after pop.
  logic [7:0] mem [0:9];
  logic [3:0] wptr, rptr;
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      wptr <= 4'd0; rptr <= 4'd0; rb_dataout <= 8'h00;
    end else if (rb_enable) begin
      if (rb_push) begin
        mem[wptr] <= rb_datain;
        wptr <= (wptr == 4'd9) ? 4'd0 : wptr + 4'd1;
      end else if (rb_pop) begin
        rb_dataout <= mem[rptr];
        rptr <= (rptr == 4'd9) ? 4'd0 : rptr + 4'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Push and pop strobes must never coincide.
  always @(negedge clock) begin
    if (!reset) chk("push_pop_excl", {31'd0, rb_push & rb_pop}, 32'd0);
  end

  // One clock cycle of streaming: drive sequence byte, track handshakes, check order.
  task automatic tick();
    s_data = tx[7:0];
    #1;
    last_push  = rb_push;
    last_pop   = rb_pop;
    last_count = count;
    if (m_valid && m_ready) begin
      chk("order", {24'd0, m_data}, rx[7:0]);
      rx++;
    end
    if (s_valid && s_ready) tx++;
    @(posedge clock); #1;
  endtask

  initial begin
    int i;
    logic prev_push;
    reset = 1'b1; enable = 1'b1; s_valid = 1'b0; m_ready = 1'b0; s_data = 8'h00;
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);
    chk("rst_m_data", m_data, 0);
    reset = 1'b0;
    @(posedge clock); #1;

    // 1: single byte
    s_valid = 1'b1; s_data = 8'hA5; m_ready = 1'b1; #1;
    chk("t0_push", rb_push, 1);
    chk("t0_pop", rb_pop, 0);
    chk("t0_datain", rb_datain, 8'hA5);
    @(posedge clock); #1;
    s_valid = 1'b0; #1;
    chk("t1_pop", rb_pop, 1);
    chk("t1_count", count, 1);
    @(posedge clock); #1;
    chk("t2_m_valid", m_valid, 0);
    chk("t2_count", count, 0);
    chk("t2_pop", rb_pop, 0);
    @(posedge clock); #1;
    chk("t3_m_valid", m_valid, 1);
    chk("t3_m_data", m_data, 8'hA5);
    @(posedge clock); #1;
    chk("t4_m_valid", m_valid, 0);
    chk("t4_empty", empty, 1);

    // 2: fill with downstream stalled
    tx = 0; rx = 0;
    m_ready = 1'b0; s_valid = 1'b1;
    repeat (30) tick();
    chk("fill_accepted", tx, 11);
    chk("fill_full", full, 1);
    chk("fill_count", count, 10);
    chk("fill_s_ready", s_ready, 0);
    chk("fill_m_valid", m_valid, 1);
    chk("fill_m_data", m_data, 8'h00);

    // 3: drain in order
    s_valid = 1'b0; m_ready = 1'b1;
    for (i = 0; i < 40 && rx < 11; i++) tick();
    chk("drain_count", rx, 11);
    chk("drain_empty", empty, 1);
    chk("drain_m_valid", m_valid, 0);

    // 4: prefill 4, then stream with alternating grants
    m_ready = 1'b0; s_valid = 1'b1;
    repeat (6) tick();
    chk("prefill_count", count, 4);
    m_ready = 1'b1;
    prev_push = 1'b1;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("alt_one_strobe", {31'd0, last_push ^ last_pop}, 1);
      chk("alt_toggle", {31'd0, last_push}, {31'd0, ~prev_push});
      chk("alt_count", last_count, last_pop ? 4 : 3);
      prev_push = last_push;
    end

    // 5: enable drop during POP_WAIT
    for (i = 0; i < 10; i++) begin
      tick();
      if (last_pop) break;
    end
    chk("pw_found", {31'd0, last_pop}, 1);
    enable = 1'b0; s_data = tx[7:0]; #1;
    chk("dis_s_ready", s_ready, 0);
    chk("dis_rb_enable", rb_enable, 0);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("dis_no_push", {31'd0, last_push}, 0);
      chk("dis_no_pop", {31'd0, last_pop}, 0);
      if (k == 0) chk("dis_inflight", m_valid, 1);
    end
    chk("dis_count_held", count, 3);
    chk("dis_m_valid", m_valid, 0);
    enable = 1'b1;
    repeat (10) tick();
    s_valid = 1'b0;
    for (i = 0; i < 40 && (rx != tx || m_valid); i++) tick();
    chk("resume_all_out", rx, tx);
    chk("resume_empty", empty, 1);

    // 6: async reset while OUT_VALID with count 4
    m_ready = 1'b0; s_valid = 1'b1;
    for (i = 0; i < 20 && !(m_valid && count == 4'd4); i++) tick();
    s_valid = 1'b0;
    chk("pre_rst_count", count, 4);
    chk("pre_rst_m_valid", m_valid, 1);
    #2; reset = 1'b1; #1;
    chk("arst_m_valid", m_valid, 0);
    chk("arst_count", count, 0);
    chk("arst_empty", empty, 1);
    chk("arst_m_data", m_data, 0);
    chk("arst_s_ready", s_ready, 1);
    #20; reset = 1'b0;
    @(posedge clock); #1;
    chk("post_rst_m_valid", m_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rb_flow_ctrl.md
Name: rb_flow_ctrl

Overview:
Flow-control wrapper around the 10-entry byte ring buffer. The ring buffer has no full/empty flags, and when push and pop are both asserted it performs only the push. This block adapts an upstream valid/ready byte stream into safe push strobes. It issues pop strobes on behalf of a downstream valid/ready consumer and presents popped bytes through a one-entry output register. It tracks occupancy and never asserts rb_push and rb_pop in the same cycle.

Parameters:
DEPTH, 10, ring buffer capacity in entries
DATA_W, 8, data width
CNT_W, 4, occupancy counter width; must hold DEPTH

Ports:
clock  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  global enable; low = no new push/pop issued
s_valid  input  1  upstream byte valid
s_ready  output  1  upstream may transfer this cycle
s_data  input  DATA_W  upstream byte
m_valid  output  1  output register holds a byte
m_ready  input  1  downstream accepts byte
m_data  output  DATA_W  output byte
rb_enable  output  1  to ring buffer enable; equals enable
rb_push  output  1  to ring buffer push
rb_pop  output  1  to ring buffer pop
rb_datain  output  DATA_W  to ring buffer datain; equals s_data
rb_dataout  input  DATA_W  from ring buffer dataout; registered, valid the cycle after rb_pop
count  output  CNT_W  entries held inside the ring buffer (the output register is excluded)
full  output  1  count == DEPTH
empty  output  1  count == 0

Behaviour:
- Reset (async): state=IDLE, count=0, m_valid=0, m_data=0, last_grant=POP. Data in flight is discarded. The ring buffer shares this reset.
- FSM states:
  - IDLE: output register empty, no pop in flight.
  - POP_WAIT: pop issued last cycle; rb_dataout is valid this cycle.
  - OUT_VALID: m_valid=1.
- slot_free = (state==IDLE) | (state==OUT_VALID & m_ready).
- want_pop = enable & !empty & slot_free.
- want_push = enable & s_valid & !full.
- Arbitration when both want_push and want_pop are high: grant the one not granted last. last_grant updates only on a grant. Otherwise grant whichever wants.
- s_ready = enable & !full & !(want_pop & last_grant==PUSH). s_ready has no combinational dependency on s_valid.
- rb_push = s_valid & s_ready. rb_pop = pop granted. Both are combinational and never high together.
- count: +1 on rb_push, -1 on rb_pop, saturation impossible by construction. full and empty decode count combinationally.
- Transitions:
  - IDLE: rb_pop -> POP_WAIT.
  - POP_WAIT: m_data<=rb_dataout -> OUT_VALID. This proceeds regardless of enable.
  - OUT_VALID with m_ready: if rb_pop -> POP_WAIT, else -> IDLE.
  - OUT_VALID without m_ready: hold, m_data stable.
- Latency: rb_pop at cycle t -> m_valid=1 at cycle t+2. Peak output throughput is 1 byte per 2 cycles.
- enable low: no push/pop and s_ready=0. m_valid/m_data hold; a downstream handshake still completes (OUT_VALID->IDLE).
- Ordering: bytes appear on m_data in s_data acceptance order; there is no loss or duplication.
- Total capacity is DEPTH+1 bytes (ring buffer plus output register).

Test Plan:
1. Reset, then a single byte 0xA5 with m_ready=1 -> rb_push at t0; rb_pop at t1; m_valid=1 and m_data=0xA5 at t3; count returns to 0; empty=1.
2. m_ready=0, s_valid held high with bytes 0x00.. -> exactly 11 bytes accepted (1 in the output register, 10 in the buffer); then full=1, count=10, s_ready=0.
3. From scenario 2, raise m_ready -> 11 bytes drained in order 0x00..0x0A; rb_push and rb_pop never high together; empty=1 at end.
4. Continuous s_valid and m_ready with count>0 -> push and pop grants alternate cycle by cycle; count stays stable; data order is preserved.
5. Drop enable for 5 cycles mid-stream, including during POP_WAIT -> no strobes issued; the in-flight byte still lands in m_data; the stream resumes intact.
6. Assert reset while OUT_VALID with count=4 -> m_valid=0, count=0, state IDLE, empty=1 immediately (asynchronous).
